// File: rtl/uart_pkg.sv
// Shared constants and state encodings for the UART packet receiver.
package uart_pkg;

  localparam logic [1:0] ERR_FRAME   = 2'd1;
  localparam logic [1:0] ERR_BAD_ETX = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  localparam logic [7:0] STX_DEFAULT = 8'h02;
  localparam logic [7:0] ETX_DEFAULT = 8'h03;

  typedef enum logic [1:0] {
    WAIT_STX,
    PAYLOAD,
    WAIT_ETX
  } pkt_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/uart_byte_rx.sv
// 8N1 byte receiver: input synchronizer, mid-bit sampling, byte_valid / frame_err pulses.
// state        | meaning
// RX_IDLE      | line idle, waiting for a falling edge
// RX_START     | half-bit wait, then confirm start bit
// RX_DATA      | sampling 8 data bits, LSB first
// RX_STOP      | sampling the stop bit
// RX_WAIT_HIGH | framing error seen, waiting for line high
module uart_byte_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rxd_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       frame_err_o
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);

  logic             meta_q, sync_q, prev_q;
  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             byte_valid_q, byte_valid_d;
  logic             frame_err_q, frame_err_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q       <= 1'b1;
      sync_q       <= 1'b1;
      prev_q       <= 1'b1;
      state_q      <= RX_IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      shreg_q      <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      meta_q       <= rxd_i;
      sync_q       <= meta_q;
      prev_q       <= sync_q;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      shreg_q      <= shreg_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_d        = bit_q;
    shreg_d      = shreg_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (prev_q && !sync_q) begin
          state_d = RX_START;
          cnt_d   = HALF_LOAD;
        end
      end
      RX_START: begin
        if (cnt_q == '0) begin
          if (!sync_q) begin
            state_d = RX_DATA;
            cnt_d   = FULL_LOAD;
            bit_d   = '0;
          end else begin
            state_d = RX_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (cnt_q == '0) begin
          shreg_d = {sync_q, shreg_q[7:1]};
          cnt_d   = FULL_LOAD;
          if (bit_q == 3'd7) state_d = RX_STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RX_STOP: begin
        if (cnt_q == '0) begin
          if (sync_q) begin
            byte_valid_d = 1'b1;
            state_d      = RX_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = RX_WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RX_WAIT_HIGH: begin
        if (sync_q) state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  // shreg is stable from the stop sample until the next start bit
  assign byte_o       = shreg_q;
  assign byte_valid_o = byte_valid_q;
  assign frame_err_o  = frame_err_q;

endmodule

// File: rtl/uart_pkt_rx.sv
// Packet framer: STX, fixed-length payload, ETX; abort on framing error, bad ETX or idle timeout.
// state    | meaning
// WAIT_STX | idle, discarding bytes until STX
// PAYLOAD  | collecting payload bytes into the shadow buffer
// WAIT_ETX | payload complete, expecting ETX
module uart_pkt_rx
  import uart_pkg::*;
#(
  parameter int         CLKS_PER_BIT   = 16,
  parameter int         PAYLOAD_BYTES  = 6,
  parameter int         TIMEOUT_CYCLES = 5000,
  parameter logic [7:0] STX            = STX_DEFAULT,
  parameter logic [7:0] ETX            = ETX_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rxd,
  output logic [8*PAYLOAD_BYTES-1:0] pkt_data,
  output logic                       pkt_valid,
  output logic                       pkt_err,
  output logic [1:0]                 err_code,
  output logic [7:0]                 err_cnt,
  output logic                       busy
);

  localparam int IDX_W = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAYLOAD_BYTES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [7:0] rx_byte;
  logic       byte_valid, frame_err;

  uart_byte_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte_rx (
    .clk_i       (clk),
    .rst_i       (rst),
    .rxd_i       (rxd),
    .byte_o      (rx_byte),
    .byte_valid_o(byte_valid),
    .frame_err_o (frame_err)
  );

  pkt_state_e                        state_q, state_d;
  logic [IDX_W-1:0]                  idx_q, idx_d;
  logic [TMO_W-1:0]                  tmo_q, tmo_d;
  logic [PAYLOAD_BYTES-1:0][7:0]     shadow_q, shadow_d;
  logic [PAYLOAD_BYTES-1:0][7:0]     data_q, data_d;
  logic                              valid_q, valid_d;
  logic                              err_q, err_d;
  logic [1:0]                        code_q, code_d;
  logic [7:0]                        cnt_q, cnt_d;
  logic                              abort;
  logic [1:0]                        abort_code;
  logic                              tmo_expire;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= WAIT_STX;
      idx_q    <= '0;
      tmo_q    <= '0;
      shadow_q <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      code_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      tmo_q    <= tmo_d;
      shadow_q <= shadow_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      code_q   <= code_d;
      cnt_q    <= cnt_d;
    end
  end

  assign tmo_expire = (tmo_q == TMO_LAST);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    tmo_d      = (state_q != WAIT_STX) ? tmo_q + TMO_W'(1) : '0;
    shadow_d   = shadow_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    code_d     = code_q;
    cnt_d      = cnt_q;
    abort      = 1'b0;
    abort_code = code_q;
    case (state_q)
      WAIT_STX: begin
        if (byte_valid && rx_byte == STX) begin
          state_d = PAYLOAD;
          idx_d   = '0;
          tmo_d   = '0;
        end
      end
      PAYLOAD: begin
        if (frame_err) begin
          abort      = 1'b1;
          abort_code = ERR_FRAME;
        end else if (byte_valid) begin
          shadow_d[idx_q] = rx_byte;
          tmo_d           = '0;
          if (idx_q == IDX_LAST) state_d = WAIT_ETX;
          else                   idx_d   = idx_q + IDX_W'(1);
        end else if (tmo_expire) begin
          abort      = 1'b1;
          abort_code = ERR_TIMEOUT;
        end
      end
      WAIT_ETX: begin
        if (frame_err) begin
          abort      = 1'b1;
          abort_code = ERR_FRAME;
        end else if (byte_valid) begin
          if (rx_byte == ETX) begin
            data_d  = shadow_q;
            valid_d = 1'b1;
            state_d = WAIT_STX;
          end else begin
            abort      = 1'b1;
            abort_code = ERR_BAD_ETX;
          end
        end else if (tmo_expire) begin
          abort      = 1'b1;
          abort_code = ERR_TIMEOUT;
        end
      end
      default: state_d = WAIT_STX;
    endcase
    if (abort) begin
      state_d = WAIT_STX;
      err_d   = 1'b1;
      code_d  = abort_code;
      cnt_d   = sat_inc8(cnt_q);
    end
    if (state_d == WAIT_STX) tmo_d = '0;
  end

  assign pkt_data  = data_q;
  assign pkt_valid = valid_q;
  assign pkt_err   = err_q;
  assign err_code  = code_q;
  assign err_cnt   = cnt_q;
  assign busy      = (state_q != WAIT_STX);

endmodule
